// File: rtl/ifu.sv
// Instruction fetch unit: PC register, single-outstanding imem read, registered {inst, pc} to decode.
// Optional performance counters are enabled with the IFU_PERF_CNT_EN macro.
module ifu #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
`ifdef IFU_PERF_CNT_EN
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt
`else
    output logic [XLEN-1:0] out_pc
`endif
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] INST_BYTES = XLEN'(32'd4);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_inst_q, out_inst_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;

    // Next-state logic; a redirect takes priority over every other event.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        case (state_q)
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (imem_req_ready) begin
                        // old-address request is already accepted; its response must be dropped
                        state_d = ST_WAIT;
                        kill_d  = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else if (imem_req_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (imem_resp_valid) begin
                        state_d = ST_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (kill_q) begin
                        state_d = ST_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        state_d     = ST_HOLD;
                        out_valid_d = 1'b1;
                        out_inst_d  = imem_resp_data;
                        out_pc_d    = pc_q;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_d        = redirect_pc;
                    state_d     = ST_REQ;
                    out_valid_d = 1'b0;
                end else if (out_ready) begin
                    pc_d        = pc_q + INST_BYTES;
                    state_d     = ST_REQ;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d     = ST_REQ;
                kill_d      = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_REQ;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign imem_req_valid = (state_q == ST_REQ);
    assign imem_req_addr  = pc_q;
    assign out_valid      = out_valid_q;
    assign out_inst       = out_inst_q;
    assign out_pc         = out_pc_q;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Fetch counts consumed instructions; stall counts memory wait and decode back-pressure.
    always_comb begin
        if (out_valid_q && out_ready && !redirect_valid) begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end else begin
            perf_fetch_d = perf_fetch_q;
        end
        if ((state_q == ST_WAIT) || ((state_q == ST_HOLD) && !out_ready)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end else begin
            perf_stall_d = perf_stall_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
